// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Gated-window frequency counter. Rising edges of an asynchronous input are
// counted over a fixed gate window derived from sys_clk. The result is
// published as a 32-bit count clamped to MAX_CNT, because it feeds a
// 6-digit seven-segment display. With a 1000 ms gate the count equals the
// input frequency in Hz.
//
// Ports
//   sys_clk    in   1   system clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   meas_en    in   1   measurement enable; low stops and holds last result
//   sig_in     in   1   asynchronous signal under measurement
//   cn         out  32  last completed measurement (edges per gate)
//   cn_valid   out  1   one-cycle pulse when cn is updated
//   overflow   out  1   last measurement exceeded MAX_CNT (cn clamped)
//   gate_busy  out  1   high while the gate window is open
//
// Timing
//   A pin edge is sampled by the first synchronizer flop. The combinational
//   edge_pulse is then high during the cycle after the second flop has
//   captured it, and the pulse is counted at the end of that cycle.
//   One measurement takes GATE_CYCLES gate cycles plus one LATCH cycle.
//   Edges whose pulse falls on the LATCH cycle are not counted.
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned GATE_MS  = 1000,
    parameter int unsigned MAX_CNT  = 999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        meas_en,
    input  logic        sig_in,
    output logic [31:0] cn,
    output logic        cn_valid,
    output logic        overflow,
    output logic        gate_busy
);

    // Gate length in sys_clk cycles.
    localparam int unsigned GATE_CYCLES = CLK_FREQ / 1000 * GATE_MS;
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);

    // Display ceiling, and the value at which the edge counter parks.
    // Parking one above the ceiling keeps "exceeded" distinguishable from
    // "exactly at the ceiling" without ever wrapping.
    localparam logic [31:0] CNT_MAX = 32'(MAX_CNT);
    localparam logic [31:0] CNT_SAT = 32'(MAX_CNT) + 32'd1;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GATE  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]  state_q,     state_d;
    logic [31:0] gate_cnt_q,  gate_cnt_d;
    logic [31:0] edge_cnt_q,  edge_cnt_d;
    logic [31:0] cn_q,        cn_d;
    logic        cn_valid_q,  cn_valid_d;
    logic        overflow_q,  overflow_d;
    logic        gate_busy_q, gate_busy_d;

    // sync_q[0], sync_q[1]: two-flop synchronizer for sig_in.
    // sync_q[2]: one-cycle delayed copy of the synchronized level, used only
    // for rising-edge detection.
    logic [2:0]  sync_q, sync_d;
    logic        edge_pulse;

    // -------------------------------------------------------------------------
    // Input path
    // -------------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[1:0], sig_in};
    end

    assign edge_pulse = sync_q[1] & ~sync_q[2];

    // -------------------------------------------------------------------------
    // Measurement FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gate_cnt_d  = gate_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        cn_d        = cn_q;
        overflow_d  = overflow_q;
        cn_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (meas_en) begin
                    state_d = ST_GATE;
                end
            end

            ST_GATE: begin
                if (!meas_en) begin
                    // Abort: the partial window is thrown away and the
                    // previously published result stays on cn/overflow.
                    state_d    = ST_IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    if (edge_pulse && (edge_cnt_q < CNT_SAT)) begin
                        edge_cnt_d = edge_cnt_q + 32'd1;
                    end
                    if (gate_cnt_q == GATE_LAST) begin
                        // The edge on the final gate cycle is still counted
                        // above; the LATCH cycle reads the completed total.
                        state_d = ST_LATCH;
                    end else begin
                        gate_cnt_d = gate_cnt_q + 32'd1;
                    end
                end
            end

            ST_LATCH: begin
                if (edge_cnt_q > CNT_MAX) begin
                    cn_d       = CNT_MAX;
                    overflow_d = 1'b1;
                end else begin
                    cn_d       = edge_cnt_q;
                    overflow_d = 1'b0;
                end
                // cn_valid is registered alongside cn, so the pulse and the
                // new value appear on the same cycle.
                cn_valid_d = 1'b1;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                state_d    = meas_en ? ST_GATE : ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
            end
        endcase

        // Registered so gate_busy is glitch-free and tracks the state flop.
        gate_busy_d = (state_d == ST_GATE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            cn_q        <= '0;
            cn_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            gate_busy_q <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            cn_q        <= cn_d;
            cn_valid_q  <= cn_valid_d;
            overflow_q  <= overflow_d;
            gate_busy_q <= gate_busy_d;
            sync_q      <= sync_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cn        = cn_q;
    assign cn_valid  = cn_valid_q;
    assign overflow  = overflow_q;
    assign gate_busy = gate_busy_q;

endmodule
